arp_cache_assoc: RTL and testbench

ARP_CACHE_ASSOC -- requirements
Module: arp_cache_assoc

---
 rtl/arp_cache_assoc.sv | 269 ++++++++++++++++++++++++++
 tb/tb_arp_cache_assoc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/arp_cache_assoc.sv
// arp_cache_assoc: set-associative IP->MAC cache with epoch-based expiry,
// round-robin replacement, a background scrubber and a clear sweep.

// Liveness of one stored way against the current epoch and expiry threshold.
module arp_cache_assoc_way #(
    parameter int AGE_WIDTH = 8
) (
    input  logic                 vld_i,
    input  logic [AGE_WIDTH-1:0] ts_i,
    input  logic [AGE_WIDTH-1:0] epoch_i,
    input  logic [AGE_WIDTH-1:0] max_age_i,
    output logic                 live_o
);
    logic [AGE_WIDTH-1:0] age;

    // modular age; the scrubber retires entries before the epoch can wrap onto them
    assign age    = epoch_i - ts_i;
    assign live_o = vld_i && ((max_age_i == '0) || (age < max_age_i));
endmodule

module arp_cache_assoc #(
    parameter int CACHE_ADDR_WIDTH = 6,
    parameter int WAYS             = 2,
    parameter int AGE_WIDTH        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 query_request_valid,
    output logic                 query_request_ready,
    input  logic [31:0]          query_request_ip,
    output logic                 query_response_valid,
    input  logic                 query_response_ready,
    output logic                 query_response_error,
    output logic [47:0]          query_response_mac,
    input  logic                 write_request_valid,
    output logic                 write_request_ready,
    input  logic [31:0]          write_request_ip,
    input  logic [47:0]          write_request_mac,
    input  logic [47:0]          local_mac,
    input  logic [31:0]          local_ip,
    input  logic                 clear_cache,
    input  logic                 age_tick,
    input  logic [AGE_WIDTH-1:0] max_age
);
    localparam int          SETS      = 1 << CACHE_ADDR_WIDTH;
    localparam int          VW        = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [31:0] BCAST_IP  = 32'hFFFF_FFFF;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef logic [CACHE_ADDR_WIDTH-1:0] set_t;
    typedef logic [VW-1:0]               way_t;
    typedef struct packed {
        logic        err;
        logic [47:0] mac;
    } qres_t;

    function automatic set_t set_of(input logic [31:0] ip);
        return set_t'(ip[31:16] ^ ip[15:0]);
    endfunction

    // ---------------- storage ----------------
    logic [WAYS-1:0]                vld_q  [SETS];
    logic [WAYS-1:0][31:0]          eip_q  [SETS];
    logic [WAYS-1:0][47:0]          emac_q [SETS];
    logic [WAYS-1:0][AGE_WIDTH-1:0] ets_q  [SETS];
    way_t                           vptr_q [SETS];

    logic [AGE_WIDTH-1:0] epoch_q;
    logic                 sweep_q, sweep_d;
    set_t                 sw_idx_q, sw_idx_d;
    set_t                 scrub_idx_q;

    // ---------------- query side ----------------
    logic [1:0]  qpipe_q;      // [0]: lookup this cycle, [1]: present result next edge
    logic [31:0] q_ip_q;
    qres_t       q_res, q_res_q, rsp_q;
    logic        rsp_vld_q;
    logic        q_acc, q_busy_q, q_busy_d, qry_rdy_q, qry_rdy_d;
    set_t        q_set;
    logic [WAYS-1:0] q_live;

    // ---------------- write side ----------------
    logic        wr_acc, wr_pend_q, wr_rdy_q, wr_rdy_d;
    logic [31:0] wr_ip_q;
    logic [47:0] wr_mac_q;
    set_t        w_set;
    logic [WAYS-1:0] w_live;
    logic        w_discard, w_commit, w_hit, w_free, w_adv;
    way_t        w_hit_idx, w_free_idx, w_way;

    logic [WAYS-1:0] s_live;

    assign q_set = set_of(q_ip_q);
    assign w_set = set_of(wr_ip_q);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        arp_cache_assoc_way #(.AGE_WIDTH(AGE_WIDTH)) u_qchk (
            .vld_i(vld_q[q_set][w]), .ts_i(ets_q[q_set][w]),
            .epoch_i(epoch_q), .max_age_i(max_age), .live_o(q_live[w]));
        arp_cache_assoc_way #(.AGE_WIDTH(AGE_WIDTH)) u_wchk (
            .vld_i(vld_q[w_set][w]), .ts_i(ets_q[w_set][w]),
            .epoch_i(epoch_q), .max_age_i(max_age), .live_o(w_live[w]));
        arp_cache_assoc_way #(.AGE_WIDTH(AGE_WIDTH)) u_schk (
            .vld_i(vld_q[scrub_idx_q][w]), .ts_i(ets_q[scrub_idx_q][w]),
            .epoch_i(epoch_q), .max_age_i(max_age), .live_o(s_live[w]));
    end

    // Lookup: reserved addresses first, then any live matching way.
    always_comb begin
        q_res = '{err: 1'b1, mac: '0};
        if (q_ip_q == local_ip) begin
            q_res = '{err: 1'b0, mac: local_mac};
        end else if (q_ip_q == BCAST_IP) begin
            q_res = '{err: 1'b0, mac: BCAST_MAC};
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (q_live[w] && (eip_q[q_set][w] == q_ip_q)) begin
                    q_res = '{err: 1'b0, mac: emac_q[q_set][w]};
                end
            end
        end
    end

    // Way selection for a commit: in-place update, else lowest dead way, else victim.
    always_comb begin
        w_hit      = 1'b0;
        w_free     = 1'b0;
        w_hit_idx  = '0;
        w_free_idx = '0;
        w_adv      = 1'b0;
        w_way      = vptr_q[w_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld_q[w_set][w] && (eip_q[w_set][w] == wr_ip_q)) begin
                w_hit     = 1'b1;
                w_hit_idx = way_t'(w);
            end
            if (!w_live[w]) begin
                w_free     = 1'b1;
                w_free_idx = way_t'(w);
            end
        end
        if (w_hit) begin
            w_way = w_hit_idx;
        end else if (w_free) begin
            w_way = w_free_idx;
        end else begin
            w_adv = 1'b1;
        end
    end

    // Reserved addresses are swallowed; a write landing during a sweep is cleared with it.
    assign w_discard = (wr_ip_q == local_ip) || (wr_ip_q == BCAST_IP);
    assign w_commit  = wr_pend_q && !w_discard && !sweep_q;

    assign q_acc    = query_request_valid && qry_rdy_q;
    assign q_busy_d = q_acc || (q_busy_q && !(rsp_vld_q && query_response_ready));
    assign wr_acc   = write_request_valid && wr_rdy_q;

    // Clear sweep sequencing; a new pulse restarts from set 0.
    always_comb begin
        sweep_d  = sweep_q;
        sw_idx_d = sw_idx_q;
        if (sweep_q) begin
            if (sw_idx_q == set_t'(SETS - 1)) sweep_d = 1'b0;
            else                              sw_idx_d = sw_idx_q + 1'b1;
        end
        if (clear_cache) begin
            sweep_d  = 1'b1;
            sw_idx_d = '0;
        end
    end

    // Readies stay low for one extra cycle after a sweep ends.
    assign qry_rdy_d = !q_busy_d && !sweep_d && !sweep_q;
    assign wr_rdy_d  = !wr_acc && !sweep_d && !sweep_q;

    // Epoch counter, sweep state and scrubber index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epoch_q     <= '0;
            sweep_q     <= 1'b1;
            sw_idx_q    <= '0;
            scrub_idx_q <= '0;
        end else begin
            if (age_tick) epoch_q <= epoch_q + 1'b1;
            sweep_q  <= sweep_d;
            sw_idx_q <= sw_idx_d;
            if (!w_commit && !sweep_q) scrub_idx_q <= scrub_idx_q + 1'b1;
        end
    end

    // Query pipeline: accept, lookup, then hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qpipe_q   <= '0;
            q_busy_q  <= 1'b0;
            qry_rdy_q <= 1'b0;
            q_ip_q    <= '0;
            q_res_q   <= '0;
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
        end else begin
            qpipe_q   <= {qpipe_q[0], q_acc};
            q_busy_q  <= q_busy_d;
            qry_rdy_q <= qry_rdy_d;
            if (q_acc)      q_ip_q  <= query_request_ip;
            if (qpipe_q[0]) q_res_q <= q_res;
            if (qpipe_q[1]) begin
                rsp_vld_q <= 1'b1;
                rsp_q     <= q_res_q;
            end else if (rsp_vld_q && query_response_ready) begin
                rsp_vld_q <= 1'b0;
            end
        end
    end

    // Write request capture; commit happens on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend_q <= 1'b0;
            wr_rdy_q  <= 1'b0;
            wr_ip_q   <= '0;
            wr_mac_q  <= '0;
        end else begin
            wr_pend_q <= wr_acc;
            wr_rdy_q  <= wr_rdy_d;
            if (wr_acc) begin
                wr_ip_q  <= write_request_ip;
                wr_mac_q <= write_request_mac;
            end
        end
    end

    // Valid bits and victim pointers: commit, else scrub; sweep clearing wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                vld_q[s]  <= '0;
                vptr_q[s] <= '0;
            end
        end else begin
            if (w_commit) begin
                vld_q[w_set][w_way] <= 1'b1;
                if (w_adv) begin
                    vptr_q[w_set] <= (vptr_q[w_set] == way_t'(WAYS - 1)) ? '0
                                                                         : vptr_q[w_set] + 1'b1;
                end
            end else if (!sweep_q) begin
                vld_q[scrub_idx_q] <= s_live;
            end
            if (sweep_q) vld_q[sw_idx_q] <= '0;
        end
    end

    // Entry payload; only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            eip_q[w_set][w_way]  <= wr_ip_q;
            emac_q[w_set][w_way] <= wr_mac_q;
            ets_q[w_set][w_way]  <= epoch_q;
        end
    end

    assign query_request_ready  = qry_rdy_q;
    assign write_request_ready  = wr_rdy_q;
    assign query_response_valid = rsp_vld_q;
    assign query_response_error = rsp_q.err;
    assign query_response_mac   = rsp_q.mac;
endmodule

// File: tb/tb_arp_cache_assoc.sv
// Directed bench for arp_cache_assoc: reset sweep, hit/miss, replacement,
// expiry, reserved addresses, clear restart, response hold, reset abort.
module tb_arp_cache_assoc;
    localparam int AW   = 6;
    localparam int WAYS = 2;
    localparam int AGEW = 8;
    localparam logic [31:0] LIP  = 32'hC0A8_0001;
    localparam logic [47:0] LMAC = 48'h0200_DEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            query_request_valid, query_request_ready;
    logic [31:0]     query_request_ip;
    logic            query_response_valid, query_response_ready, query_response_error;
    logic [47:0]     query_response_mac;
    logic            write_request_valid, write_request_ready;
    logic [31:0]     write_request_ip;
    logic [47:0]     write_request_mac;
    logic [47:0]     local_mac;
    logic [31:0]     local_ip;
    logic            clear_cache, age_tick;
    logic [AGEW-1:0] max_age;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arp_cache_assoc #(.CACHE_ADDR_WIDTH(AW), .WAYS(WAYS), .AGE_WIDTH(AGEW)) dut (
        .clk(clk), .rst_n(rst_n),
        .query_request_valid(query_request_valid), .query_request_ready(query_request_ready),
        .query_request_ip(query_request_ip),
        .query_response_valid(query_response_valid), .query_response_ready(query_response_ready),
        .query_response_error(query_response_error), .query_response_mac(query_response_mac),
        .write_request_valid(write_request_valid), .write_request_ready(write_request_ready),
        .write_request_ip(write_request_ip), .write_request_mac(write_request_mac),
        .local_mac(local_mac), .local_ip(local_ip), .clear_cache(clear_cache),
        .age_tick(age_tick), .max_age(max_age));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] mac_of(input logic [31:0] ip);
        return {16'h0200, ip};
    endfunction

    task automatic do_write(input logic [31:0] ip, input logic [47:0] mac);
        int n;
        n = 0;
        write_request_ip    = ip;
        write_request_mac   = mac;
        write_request_valid = 1'b1;
        while (!write_request_ready && n < 200) begin tick(); n++; end
        chk("wr_rdy", 64'(write_request_ready), 64'd1);
        tick();
        write_request_valid = 1'b0;
        tick();
    endtask

    task automatic check_query(input string tag, input logic [31:0] ip,
                               input logic exp_err, input logic [47:0] exp_mac);
        int n, lat;
        n = 0;
        query_request_ip    = ip;
        query_request_valid = 1'b1;
        while (!query_request_ready && n < 200) begin tick(); n++; end
        chk({tag, "_qrdy"}, 64'(query_request_ready), 64'd1);
        tick();
        query_request_valid = 1'b0;
        lat = 0;
        while (!query_response_valid && lat < 20) begin tick(); lat++; end
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk({tag, "_err"}, 64'(query_response_error), 64'(exp_err));
        chk({tag, "_mac"}, 64'(query_response_mac), 64'(exp_mac));
        tick();
    endtask

    task automatic pulse_tick();
        age_tick = 1'b1;
        tick();
        age_tick = 1'b0;
        tick();
    endtask

    initial begin
        int   n;
        logic seen;
        query_request_valid  = 1'b0;
        query_request_ip     = '0;
        query_response_ready = 1'b1;
        write_request_valid  = 1'b0;
        write_request_ip     = '0;
        write_request_mac    = '0;
        local_mac            = LMAC;
        local_ip             = LIP;
        clear_cache          = 1'b0;
        age_tick             = 1'b0;
        max_age              = '0;

        // reset state
        repeat (3) tick();
        chk("rst_qrdy", 64'(query_request_ready), 64'd0);
        chk("rst_wrdy", 64'(write_request_ready), 64'd0);
        chk("rst_rvld", 64'(query_response_valid), 64'd0);
        chk("rst_mac",  64'(query_response_mac), 64'd0);
        chk("rst_err",  64'(query_response_error), 64'd0);

        // release: full sweep before ready
        rst_n = 1'b1;
        n = 0;
        while (!query_request_ready && n < 500) begin tick(); n++; end
        chk("rst_sweep_min", 64'(n >= 65), 64'd1);
        chk("rst_qrdy_up",   64'(query_request_ready), 64'd1);
        chk("rst_wrdy_up",   64'(write_request_ready), 64'd1);

        // reserved addresses on an empty cache
        check_query("local", LIP, 1'b0, LMAC);
        check_query("bcast", 32'hFFFF_FFFF, 1'b0, 48'hFFFF_FFFF_FFFF);
        do_write(LIP, 48'h0200_0000_0099);
        check_query("local_wr", LIP, 1'b0, LMAC);

        // basic hit/miss
        do_write(32'h0A00_0001, 48'h0200_0000_0001);
        check_query("hit1",  32'h0A00_0001, 1'b0, 48'h0200_0000_0001);
        check_query("miss2", 32'h0A00_0002, 1'b1, 48'h0);

        // round-robin replacement in set 1
        do_write(32'h0A00_0001, mac_of(32'h0A00_0001));
        do_write(32'h0A00_0041, mac_of(32'h0A00_0041));
        do_write(32'h0A00_0081, mac_of(32'h0A00_0081));
        check_query("ev_01", 32'h0A00_0001, 1'b1, 48'h0);
        check_query("ev_41", 32'h0A00_0041, 1'b0, mac_of(32'h0A00_0041));
        check_query("ev_81", 32'h0A00_0081, 1'b0, mac_of(32'h0A00_0081));
        do_write(32'h0A00_00C1, mac_of(32'h0A00_00C1));
        check_query("ev2_41", 32'h0A00_0041, 1'b1, 48'h0);
        check_query("ev2_c1", 32'h0A00_00C1, 1'b0, mac_of(32'h0A00_00C1));
        check_query("ev2_81", 32'h0A00_0081, 1'b0, mac_of(32'h0A00_0081));

        // response held while the consumer stalls
        query_response_ready = 1'b0;
        query_request_ip     = 32'h0A00_0081;
        query_request_valid  = 1'b1;
        n = 0;
        while (!query_request_ready && n < 200) begin tick(); n++; end
        tick();
        query_request_valid = 1'b0;
        n = 0;
        while (!query_response_valid && n < 20) begin tick(); n++; end
        chk("hold_lat", 64'(n), 64'd2);
        repeat (5) begin
            tick();
            chk("hold_vld",  64'(query_response_valid), 64'd1);
            chk("hold_err",  64'(query_response_error), 64'd0);
            chk("hold_mac",  64'(query_response_mac), 64'(mac_of(32'h0A00_0081)));
            chk("hold_qrdy", 64'(query_request_ready), 64'd0);
        end
        query_response_ready = 1'b1;
        tick();
        chk("hold_rel",     64'(query_response_valid), 64'd0);
        chk("hold_qrdy_up", 64'(query_request_ready), 64'd1);

        // expiry
        max_age = 8'd3;
        do_write(32'h0B00_0005, mac_of(32'h0B00_0005));
        repeat (2) pulse_tick();
        check_query("age2", 32'h0B00_0005, 1'b0, mac_of(32'h0B00_0005));
        pulse_tick();
        check_query("age3", 32'h0B00_0005, 1'b1, 48'h0);
        max_age = 8'd0;
        do_write(32'h0B00_0005, mac_of(32'h0B00_0005));
        repeat (300) pulse_tick();
        check_query("age_off", 32'h0B00_0005, 1'b0, mac_of(32'h0B00_0005));

        // clear with a restart 10 cycles in
        for (int i = 1; i <= 4; i++) do_write(32'h0C00_0000 + 32'(i), mac_of(32'h0C00_0000 + 32'(i)));
        check_query("pre_clr", 32'h0C00_0003, 1'b0, mac_of(32'h0C00_0003));
        clear_cache = 1'b1;
        tick();
        clear_cache = 1'b0;
        chk("clr_qrdy_lo", 64'(query_request_ready), 64'd0);
        repeat (9) tick();
        clear_cache = 1'b1;
        tick();
        clear_cache = 1'b0;
        repeat (64) tick();
        chk("clr74_qrdy", 64'(query_request_ready), 64'd0);
        chk("clr74_wrdy", 64'(write_request_ready), 64'd0);
        tick();
        chk("clr75_qrdy", 64'(query_request_ready), 64'd1);
        chk("clr75_wrdy", 64'(write_request_ready), 64'd1);
        for (int i = 1; i <= 4; i++) check_query("post_clr", 32'h0C00_0000 + 32'(i), 1'b1, 48'h0);

        // reset mid-query: no response afterwards
        query_request_ip    = 32'h0A00_0081;
        query_request_valid = 1'b1;
        n = 0;
        while (!query_request_ready && n < 200) begin tick(); n++; end
        tick();
        query_request_valid = 1'b0;
        rst_n = 1'b0;
        seen  = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            if (query_response_valid) seen = 1'b1;
        end
        chk("rst_abort", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
